// File: rtl/param_data_memory.sv
// Single-port word memory with a valid/ready request side, a one-cycle
// registered read response, out-of-range error reporting and an FSM that
// zero-fills the whole array after reset or on a clear_start pulse.
module param_data_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  clear_start,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int                  PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]    LAST_PTR  = PTR_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable in the range compare.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  in_range;
    logic                  mem_we;
    logic [PTR_W-1:0]      req_idx;
    logic [PTR_W-1:0]      mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign req_ready = (state_q == READY) && !clear_start;
    assign busy      = (state_q == CLEAR);
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < DEPTH_EXT;
    // Only meaningful when in_range; the dropped upper bits are then zero.
    assign req_idx   = req_addr[PTR_W-1:0];

    // Next-state, clear-pointer and array write-port selection.
    always_comb begin
        // NOTE: every variable gets a default first, so no branch can infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = req_idx;
        mem_wdata = req_wdata;
        case (state_q)
            CLEAR: begin
                // clear_start is deliberately ignored here: a clear never restarts.
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                if (ptr_q == LAST_PTR) begin
                    state_d = READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            READY: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else if (accept && req_write && in_range) begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // FSM state and clear pointer; reset forces a fresh full clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage array write port.
    // NOTE: the array has no reset; the CLEAR sweep zeroes it before any read is accepted.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered response: reads return pre-edge data, any out-of-range access flags rsp_err.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= accept && !req_write;
            rsp_err   <= accept && !in_range;
            rsp_data  <= (accept && !req_write && in_range) ? mem[req_idx] : '0;
        end
    end

endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench for param_data_memory: a 256-word and a 200-word instance
// share one stimulus stream; each has its own behavioural model and queue of
// expected responses, checked by an independent negedge monitor.
module tb_param_data_memory;

    localparam int DEP0 = 256;
    localparam int DEP1 = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic       clear_start = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;

    logic [1:0] rdy, rv, re, bsy;
    logic [7:0] rdata [2];

    always #5 clock = ~clock;

    param_data_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(DEP0)) u_d256 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(rdy[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .clear_start(clear_start),
        .rsp_valid(rv[0]), .rsp_data(rdata[0]), .rsp_err(re[0]), .busy(bsy[0])
    );

    param_data_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(DEP1)) u_d200 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(rdy[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .clear_start(clear_start),
        .rsp_valid(rv[1]), .rsp_data(rdata[1]), .rsp_err(re[1]), .busy(bsy[1])
    );

    typedef struct {
        int         due;
        logic       v;
        logic       e;
        logic [7:0] d;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         depth_of[2] = '{DEP0, DEP1};
    int         remaining[2] = '{DEP0, DEP1};
    logic [7:0] mdl [2][256];

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic flush(input int i);
        if (i == 0) q0.delete();
        else        q1.delete();
    endtask

    // Monitor: a due response must match; any other cycle must show all-zero outputs.
    task automatic monitor_one(input int i);
        exp_t e;
        logic have = 1'b0;
        if (i == 0 && q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front(); have = 1'b1;
        end else if (i == 1 && q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front(); have = 1'b1;
        end
        if (have) begin
            check($sformatf("d%0d rsp_valid", depth_of[i]), rv[i], e.v);
            check($sformatf("d%0d rsp_err", depth_of[i]), re[i], e.e);
            check($sformatf("d%0d rsp_data", depth_of[i]), rdata[i], e.d);
        end else begin
            check($sformatf("d%0d idle outputs", depth_of[i]), {rv[i], re[i], rdata[i]}, 0);
        end
    endtask

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) monitor_one(i);
    end

    // Reference model: one call per cycle with the inputs about to be sampled.
    task automatic model_step(input int i);
        exp_t e;
        int   a;
        if (reset) begin
            remaining[i] = depth_of[i];
            for (int k = 0; k < 256; k++) mdl[i][k] = 8'h00;
            flush(i);
            check($sformatf("d%0d ready in reset", depth_of[i]), rdy[i], 0);
            check($sformatf("d%0d busy in reset", depth_of[i]), bsy[i], 1);
            return;
        end
        check($sformatf("d%0d req_ready", depth_of[i]), rdy[i], (remaining[i] == 0) && !clear_start);
        check($sformatf("d%0d busy", depth_of[i]), bsy[i], remaining[i] > 0);
        if (remaining[i] > 0) begin
            remaining[i]--;
        end else if (clear_start) begin
            remaining[i] = depth_of[i];
            for (int k = 0; k < 256; k++) mdl[i][k] = 8'h00;
        end else if (req_valid) begin
            a     = int'(req_addr);
            e.due = cyc + 1;
            if (req_write) begin
                if (a < depth_of[i]) begin
                    mdl[i][a] = req_wdata;
                end else begin
                    e.v = 1'b0; e.e = 1'b1; e.d = 8'h00;
                    push(i, e);
                end
            end else begin
                e.v = 1'b1;
                e.e = (a >= depth_of[i]);
                e.d = e.e ? 8'h00 : mdl[i][a];
                push(i, e);
            end
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic w,
                         input logic [7:0] a, input logic [7:0] d, input logic clr);
        @(negedge clock);
        #1;
        reset = rst; req_valid = v; req_write = w; req_addr = a; req_wdata = d; clear_start = clr;
        #1;
        model_step(0);
        model_step(1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic hold_reset(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic wr_req(input logic [7:0] a, input logic [7:0] d);
        drive(1'b0, 1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd_req(input logic [7:0] a);
        drive(1'b0, 1'b1, 1'b0, a, 8'h00, 1'b0);
    endtask

    // Issue a read, then hit reset just after the edge that registers its response.
    task automatic reset_on_response(input logic [7:0] a);
        rd_req(a);
        @(posedge clock);
        #1;
        reset = 1'b1; req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            flush(i);
            remaining[i] = depth_of[i];
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d outputs at reset", depth_of[i]), {rv[i], re[i], rdata[i]}, 0);
            check($sformatf("d%0d busy at reset", depth_of[i]), bsy[i], 1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, d;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 256; k++) mdl[i][k] = 8'h00;

        // Power-up reset, then the full post-reset clear.
        hold_reset(4);
        idle(DEP0 + 2);
        rd_req(8'h00); rd_req(8'h7F); rd_req(8'hFF);

        // Write then read-back, back-to-back reads.
        wr_req(8'h10, 8'hA5);
        rd_req(8'h10);
        rd_req(8'h10);
        rd_req(8'h11);

        // Range boundary of the 200-word instance.
        wr_req(8'hC8, 8'h5A);
        rd_req(8'hC8);
        rd_req(8'hC7);
        wr_req(8'hC7, 8'h3C);
        rd_req(8'hC7);
        idle(2);

        // clear_start beats a simultaneous write; array reads back zero afterwards.
        for (int k = 0; k < 4; k++) wr_req(8'(k), 8'hFF);
        drive(1'b0, 1'b1, 1'b1, 8'h04, 8'h77, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        idle(DEP0 - 1);
        for (int k = 0; k < 5; k++) rd_req(8'(k));
        idle(2);

        // Reset at cycle 100 of a clear.
        wr_req(8'h20, 8'h99);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        idle(100);
        hold_reset(3);
        idle(DEP0 + 1);
        rd_req(8'h20);

        // Reset on the cycle a read response is due.
        wr_req(8'h30, 8'h42);
        reset_on_response(8'h30);
        hold_reset(2);
        idle(DEP0 + 1);
        rd_req(8'h30);

        // Randomized traffic with toggling req_valid and occasional clears.
        for (int n = 0; n < 3000; n++) begin
            a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            drive(1'b0, $urandom_range(0, 99) < 55, 1'($urandom_range(0, 1)), a, d,
                  $urandom_range(0, 399) == 0);
        end
        idle(3);
        check("d256 queue drained", q0.size(), 0);
        check("d200 queue drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
